// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 8N1 UART receiver and transmitter.
// Both FSMs take their state encodings from here.
package uart_pkg;

  localparam int DATA_W          = 8;
  localparam int IDX_W           = $clog2(DATA_W);
  localparam int CLK_PER_BIT_DEF = 217;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Counter value at which the start bit is re-checked (half a bit in).
  function automatic int mid_count(input int cpb);
    return (cpb - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for one asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch on reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver, mid-bit sampling, LSB first.
// Emits a one-cycle rx_valid per good byte and a one-cycle frame_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_per_bit = CLK_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int CW = $clog2(clk_per_bit);
  localparam logic [CW-1:0] C_LAST = CW'(clk_per_bit - 1);
  localparam logic [CW-1:0] C_MID  = CW'(mid_count(clk_per_bit));
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] I_ONE  = IDX_W'(1);

  logic              w_rx_s;
  logic              w_cnt_end;

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              w_valid;
  logic              r_ferr;
  logic              w_ferr;
  logic              r_busy;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  assign w_cnt_end = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_busy  <= (w_next != RX_IDLE);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_next = RX_START;
          w_cnt  = '0;
        end
      end
      RX_START: begin
        if (r_cnt == C_MID) begin
          w_cnt = '0;
          if (w_rx_s) begin
            w_next = RX_IDLE;
          end else begin
            w_next = RX_DATA;
            w_idx  = '0;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      RX_DATA: begin
        if (w_cnt_end) begin
          w_cnt          = '0;
          w_shift[r_idx] = w_rx_s;
          if (r_idx == I_LAST) begin
            w_next = RX_STOP;
          end else begin
            w_idx = r_idx + I_ONE;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
        if (w_cnt_end) begin
          w_cnt = '0;
          if (w_rx_s) begin
            w_data  = r_shift;
            w_valid = 1'b1;
            w_next  = RX_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_next = RX_IDLE;
        end
      end
      default: begin
        w_next = RX_IDLE;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = r_busy;

endmodule
